// File: rtl/mem_arbiter2.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// the instruction-fetch port (I) and the load/store port (D).
// Round-robin fairness, with a bounded D-side lock for atomic sequences.
// Read data returns one cycle after the grant and is steered by the
// registered rvalid of the requester that issued it.
module mem_arbiter2 #(
    parameter int WORD     = 32,
    parameter int ADDR     = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    input  logic            d_lock,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    output logic [ADDR-1:0] m_A,
    output logic            m_W,
    output logic [WORD-1:0] m_D,
    input  logic [WORD-1:0] m_Q
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    typedef enum logic {
        PRIO_I = 1'b0,
        PRIO_D = 1'b1
    } prio_e;

    prio_e            prio_q, prio_d;
    logic             last_was_d_q, last_was_d_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             i_rvalid_q, d_rvalid_q;
    logic [ADDR-1:0]  m_a_q;
    logic [WORD-1:0]  m_d_q;
    logic             lock_active;
    logic             grant_i, grant_d;

    // D keeps the slot only while it still holds the lock, owned the last
    // grant and has not used up its run of consecutive conflicting grants.
    always_comb begin
        lock_active = d_lock & last_was_d_q & (lock_cnt_q < LOCK_MAX_C);
    end

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (lock_active || prio_q == PRIO_D) begin
                    grant_d = 1'b1;
                end else begin
                    grant_i = 1'b1;
                end
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Memory drive; address and write data hold when idle to avoid toggling.
    always_comb begin
        m_A = m_a_q;
        m_D = m_d_q;
        m_W = 1'b0;
        if (grant_i) begin
            m_A = i_addr;
        end else if (grant_d) begin
            m_A = d_addr;
            m_W = d_we;
            m_D = d_wdata;
        end
    end

    // Next arbitration state: the winner hands priority to the other side,
    // and the lock counter only advances on D grants that beat a waiting I.
    always_comb begin
        prio_d       = prio_q;
        last_was_d_d = last_was_d_q;
        lock_cnt_d   = lock_cnt_q;
        if (grant_i) begin
            prio_d       = PRIO_D;
            last_was_d_d = 1'b0;
            lock_cnt_d   = '0;
        end else if (grant_d) begin
            prio_d       = PRIO_I;
            last_was_d_d = 1'b1;
            if (i_req) begin
                lock_cnt_d = (lock_cnt_q < LOCK_MAX_C) ? lock_cnt_q + 1'b1 : lock_cnt_q;
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    // State registers with synchronous reset; rvalid tracks last cycle's read grant.
    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so every flop samples the values
        // from before the edge, independent of statement order.
        if (rst) begin
            prio_q       <= PRIO_I;
            last_was_d_q <= 1'b0;
            lock_cnt_q   <= '0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            m_a_q        <= '0;
            m_d_q        <= '0;
        end else begin
            prio_q       <= prio_d;
            last_was_d_q <= last_was_d_d;
            lock_cnt_q   <= lock_cnt_d;
            i_rvalid_q   <= grant_i;
            d_rvalid_q   <= grant_d & ~d_we;
            m_a_q        <= m_A;
            m_d_q        <= m_D;
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    // A read granted just before reset rises must not return data in the
    // reset cycle, so the registered valids are also masked by rst.
    assign i_rvalid = i_rvalid_q & ~rst;
    assign d_rvalid = d_rvalid_q & ~rst;
    assign i_rdata  = m_Q;
    assign d_rdata  = m_Q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Self-checking bench for mem_arbiter2 with a behavioural single-port memory.
// Expected read data is pushed to per-port queues when a grant is expected
// and popped by a monitor in the cycle the data must return.
module tb_mem_arbiter2;

    localparam int WORD     = 32;
    localparam int ADDR     = 16;
    localparam int LOCK_MAX = 4;

    typedef struct {
        int unsigned     cyc;
        logic [WORD-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_req = 1'b0;
    logic [ADDR-1:0] i_addr = '0;
    logic            i_gnt;
    logic            i_rvalid;
    logic [WORD-1:0] i_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [ADDR-1:0] d_addr = '0;
    logic [WORD-1:0] d_wdata = '0;
    logic            d_lock = 1'b0;
    logic            d_gnt;
    logic            d_rvalid;
    logic [WORD-1:0] d_rdata;
    logic [ADDR-1:0] m_A;
    logic            m_W;
    logic [WORD-1:0] m_D;
    logic [WORD-1:0] m_Q;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;

    exp_t            i_q[$];
    exp_t            d_q[$];
    logic [WORD-1:0] shadow [logic [ADDR-1:0]];
    logic [WORD-1:0] mem [0:65535];
    logic [WORD-1:0] m_q_r = '0;

    always #5 clk = ~clk;

    mem_arbiter2 #(.WORD(WORD), .ADDR(ADDR), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_A(m_A), .m_W(m_W), .m_D(m_D), .m_Q(m_Q)
    );

    // Single-port synchronous memory: write at the edge, else registered read.
    always @(posedge clk) begin
        if (m_W === 1'b1) mem[m_A] <= m_D;
        else              m_q_r    <= mem[m_A];
    end
    assign m_Q = m_q_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Return-path monitor: each rvalid must match exactly the queue entry due this cycle.
    always @(negedge clk) begin : monitor
        logic iv_exp;
        logic dv_exp;
        #2;
        if (mon_en) begin
            iv_exp = (i_q.size() > 0) && (i_q[0].cyc == cyc);
            dv_exp = (d_q.size() > 0) && (d_q[0].cyc == cyc);
            tests++;
            if (i_rvalid !== iv_exp) begin
                fails++;
                $display("FAIL i_rvalid cyc=%0d got=%b expected=%b", cyc, i_rvalid, iv_exp);
            end else if (iv_exp) begin
                tests++;
                if (i_rdata !== i_q[0].data) begin
                    fails++;
                    $display("FAIL i_rdata cyc=%0d got=%h expected=%h", cyc, i_rdata, i_q[0].data);
                end
            end
            if (iv_exp) void'(i_q.pop_front());
            tests++;
            if (d_rvalid !== dv_exp) begin
                fails++;
                $display("FAIL d_rvalid cyc=%0d got=%b expected=%b", cyc, d_rvalid, dv_exp);
            end else if (dv_exp) begin
                tests++;
                if (d_rdata !== d_q[0].data) begin
                    fails++;
                    $display("FAIL d_rdata cyc=%0d got=%h expected=%h", cyc, d_rdata, d_q[0].data);
                end
            end
            if (dv_exp) void'(d_q.pop_front());
        end
    end

    task automatic preload(input logic [ADDR-1:0] a, input logic [WORD-1:0] v);
        mem[a]    <= v;
        shadow[a]  = v;
    endtask

    task automatic push_i(input logic [ADDR-1:0] a);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = shadow[a];
        i_q.push_back(e);
    endtask

    task automatic push_d(input logic [ADDR-1:0] a);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = shadow[a];
        d_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic r, input logic ir, input logic [ADDR-1:0] ia,
                         input logic dr, input logic dw, input logic [ADDR-1:0] da,
                         input logic [WORD-1:0] dd, input logic dl);
        @(negedge clk);
        rst     = r;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        d_lock  = dl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0040, 32'h1111_1111, 1'b0);
            mon_en = 1'b1;
            tests++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_W !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d] i_gnt=%b d_gnt=%b m_W=%b expected 0 0 0", k, i_gnt, d_gnt, m_W);
            end
        end
        // First conflict after release must go to I.
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0, 1'b0);
        tests++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_A !== 16'h0010 || m_W !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_conflict i_gnt=%b d_gnt=%b m_A=%h m_W=%b expected 1 0 0010 0", i_gnt, d_gnt, m_A, m_W);
        end
        push_i(16'h0010);
        drive(1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h0020, '0, 1'b0);
        tests++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b1 || m_A !== 16'h0020 || m_W !== 1'b0) begin
            fails++;
            $display("FAIL d_only i_gnt=%b d_gnt=%b m_A=%h m_W=%b expected 0 1 0020 0", i_gnt, d_gnt, m_A, m_W);
        end
        push_d(16'h0020);
        drive(1'b0, 1'b0, 16'h0077, 1'b0, 1'b1, 16'h0099, 32'h5555_5555, 1'b0);
        tests++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_A !== 16'h0020 || m_W !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold i_gnt=%b d_gnt=%b m_A=%h m_W=%b expected 0 0 0020 0", i_gnt, d_gnt, m_A, m_W);
        end
        idle(1);
    endtask

    task automatic test_i_only();
        logic [ADDR-1:0] a;
        for (int k = 0; k < 3; k++) begin
            a = 16'h0010 + 16'(k);
            drive(1'b0, 1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0);
            tests++;
            if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_A !== a || m_W !== 1'b0) begin
                fails++;
                $display("FAIL i_only[%0d] i_gnt=%b d_gnt=%b m_A=%h m_W=%b expected 1 0 %h 0", k, i_gnt, d_gnt, m_A, m_W, a);
            end
            push_i(a);
        end
        idle(2);
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'h1234, 32'hDEAD_BEEF, 1'b0);
        tests++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_W !== 1'b1 || m_A !== 16'h1234 || m_D !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL d_write d_gnt=%b i_gnt=%b m_W=%b m_A=%h m_D=%h expected 1 0 1 1234 deadbeef", d_gnt, i_gnt, m_W, m_A, m_D);
        end
        shadow[16'h1234] = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h1234, '0, 1'b0);
        tests++;
        if (d_gnt !== 1'b1 || m_W !== 1'b0 || m_A !== 16'h1234) begin
            fails++;
            $display("FAIL d_read d_gnt=%b m_W=%b m_A=%h expected 1 0 1234", d_gnt, m_W, m_A);
        end
        push_d(16'h1234);
        idle(2);
    endtask

    task automatic test_back_to_back_conflict();
        logic [ADDR-1:0] ia;
        logic [ADDR-1:0] da;
        logic            exp_i;
        ia = 16'h0030;
        da = 16'h0020;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k % 2 == 0);
            drive(1'b0, 1'b1, ia, 1'b1, 1'b0, da, '0, 1'b0);
            tests++;
            if (i_gnt !== exp_i || d_gnt !== ~exp_i || m_A !== (exp_i ? ia : da) || m_W !== 1'b0) begin
                fails++;
                $display("FAIL conflict[%0d] i_gnt=%b d_gnt=%b m_A=%h m_W=%b expected %b %b %h 0",
                         k, i_gnt, d_gnt, m_A, m_W, exp_i, ~exp_i, exp_i ? ia : da);
            end
            if (exp_i) begin push_i(ia); ia++; end
            else       begin push_d(da); da++; end
        end
        idle(2);
    endtask

    task automatic test_lock_bound();
        logic [ADDR-1:0] ia;
        logic [ADDR-1:0] da;
        logic            exp_i;
        // A lone D grant leaves last grant = D with a cleared lock count.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0027, '0, 1'b0);
        tests++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            fails++;
            $display("FAIL lock_setup d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt);
        end
        push_d(16'h0027);
        ia = 16'h0033;
        da = 16'h0028;
        for (int k = 0; k < LOCK_MAX + 2; k++) begin
            exp_i = (k == LOCK_MAX);
            drive(1'b0, 1'b1, ia, 1'b1, 1'b0, da, '0, 1'b1);
            tests++;
            if (i_gnt !== exp_i || d_gnt !== ~exp_i) begin
                fails++;
                $display("FAIL lock[%0d] i_gnt=%b d_gnt=%b expected %b %b", k, i_gnt, d_gnt, exp_i, ~exp_i);
            end
            if (exp_i) begin push_i(ia); ia++; end
            else       begin push_d(da); da++; end
        end
        // Dropping d_lock hands the very next conflict to prio, which is I.
        drive(1'b0, 1'b1, ia, 1'b1, 1'b0, da, '0, 1'b0);
        tests++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            fails++;
            $display("FAIL lock_drop i_gnt=%b d_gnt=%b expected 1 0", i_gnt, d_gnt);
        end
        push_i(ia);
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0021, '0, 1'b0);
        tests++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL mid_read_grant d_gnt=%b expected 1", d_gnt);
        end
        push_d(16'h0021);
        drive(1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 16'h0021, 32'h2222_2222, 1'b0);
        // The read in flight is dropped by reset; nothing may return.
        d_q.delete();
        i_q.delete();
        tests++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_W !== 1'b0) begin
            fails++;
            $display("FAIL mid_read_rst i_gnt=%b d_gnt=%b m_W=%b expected 0 0 0", i_gnt, d_gnt, m_W);
        end
        idle(2);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) preload(ADDR'(a), 32'hC0DE_0000 | 32'(a));
        preload(16'h0010, 32'hA000_00A0);
        preload(16'h0011, 32'hA000_00A1);
        preload(16'h0012, 32'hA000_00A2);
        preload(16'h1234, 32'h0000_0000);

        test_reset();
        test_i_only();
        test_write_read();
        test_back_to_back_conflict();
        test_lock_bound();
        test_reset_mid_read();

        tests++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            fails++;
            $display("FAIL drain i_q=%0d d_q=%0d expected 0 0", i_q.size(), d_q.size());
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-requester arbiter that shares one single-port synchronous memory (32-bit word, 16-bit address, 1-cycle registered read) between the instruction-fetch port (I) and the load/store port (D).
- Issues at most one access per cycle and routes read data back to the requester that issued it.
- Sits between the core pipeline and the main memory instance.
- Fairness is round-robin; a bounded lock supports D-side atomic sequences.

Parameters:
- WORD, 32, data word width.
- ADDR, 16, address width.
- LOCK_MAX, 4, maximum consecutive D grants while d_lock is held before one forced I slot.

Ports:
- clk  input  1  clock. Everything is sampled on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_req  input  1  instruction read request. Held with i_addr stable until granted.
- i_addr  input  ADDR  instruction read address.
- i_gnt  output  1  I request accepted this cycle (combinational).
- i_rvalid  output  1  i_rdata valid this cycle.
- i_rdata  output  WORD  instruction read data.
- d_req  input  1  data request. Held with d_we, d_addr and d_wdata stable until granted.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR  data address.
- d_wdata  input  WORD  write data.
- d_lock  input  1  keep D priority for back-to-back accesses (atomic sequence).
- d_gnt  output  1  D request accepted this cycle (combinational).
- d_rvalid  output  1  d_rdata valid this cycle. Never asserted for writes.
- d_rdata  output  WORD  data read data.
- m_A  output  ADDR  memory address.
- m_W  output  1  memory write enable.
- m_D  output  WORD  memory write data.
- m_Q  input  WORD  memory read data. Valid the cycle after a read is issued; holds its value during writes.

Behaviour:
- Reset (rst=1 at posedge):
  - prio <= I, lock_cnt <= 0, i_rvalid_r <= 0, d_rvalid_r <= 0.
  - While rst is high: i_gnt = d_gnt = 0 and m_W = 0, so no memory write can occur.
  - An in-flight read whose data would return in the cycle after reset is dropped; its rvalid stays 0.
- Grant, combinational from the requests and registered state:
  - Only i_req: I granted.
  - Only d_req: D granted.
  - Both requesting, with lock_active = d_lock & last_was_D & (lock_cnt < LOCK_MAX):
    - If lock_active, D is granted.
    - Otherwise the side named by prio is granted.
  - Neither requesting: no grant, m_W = 0, and m_A/m_D hold their previous value (avoids toggling).
- Memory drive:
  - Granted I: m_A = i_addr, m_W = 0.
  - Granted D: m_A = d_addr, m_W = d_we, m_D = d_wdata.
- Return path:
  - i_rvalid_r <= i_gnt.
  - d_rvalid_r <= d_gnt & ~d_we.
  - i_rdata = d_rdata = m_Q. Only the matching rvalid qualifies the data.
  - Read latency is exactly 1 cycle after the grant.
  - Back-to-back grants give one result per cycle with no bubbles.
- Registered state updates on each posedge (rst=0):
  - I granted: prio <= D, last_was_D <= 0, lock_cnt <= 0.
  - D granted: prio <= I, last_was_D <= 1.
    - If the grant happened while i_req was also pending, lock_cnt <= lock_cnt + 1 (saturating at LOCK_MAX).
    - Else lock_cnt <= 0.
  - No grant: prio, last_was_D and lock_cnt hold.
  - d_lock dropping clears lock_active immediately; the next conflict follows prio.
- Fairness: under continuous dual requests the grants alternate I,D,I,D. With d_lock held, at most LOCK_MAX consecutive conflicting D grants occur, then I gets exactly one slot.
- Read-after-write to the same address on consecutive D grants returns the newly written data, because the memory write completes at the write edge.
- Simultaneous req assert and grant: a request is accepted in the same cycle it first appears; there is no request registering stage.

Test Plan:
- Reset: hold rst 3 cycles with i_req=d_req=1 and d_we=1 -> i_gnt=d_gnt=0 and m_W=0 throughout; both rvalids 0 on the first cycle after release. First conflict grants I (prio=I).
- I only: i_req with i_addr 0x0010, 0x0011, 0x0012 back-to-back (preloaded mem[0x10..0x12]=A0,A1,A2) -> i_gnt=1 on each cycle; i_rvalid on the 3 following cycles with i_rdata A0,A1,A2.
- Conflict, no lock: both requesting continuously for 6 cycles, D doing reads -> grant sequence I,D,I,D,I,D. Each rvalid arrives 1 cycle after its own grant; the other rvalid stays 0 in that cycle.
- D write then read: D write 0xDEADBEEF to 0x1234, then D read 0x1234 -> no d_rvalid after the write; d_rvalid with d_rdata=0xDEADBEEF one cycle after the read grant.
- Lock bound: LOCK_MAX=4, i_req held, d_req+d_lock held, last grant D -> D granted 4 consecutive cycles, then I for 1 cycle, then D again.
- Reset mid-read: D read granted at cycle n, rst=1 at cycle n+1 -> d_rvalid=0 at n+1 and after; no spurious data return.
